// File: rtl/wt_mem_port_arbiter_pkg.sv
// Shared constants, width helpers and the tagged transaction ID type for the
// write-through memory port arbiter.
package wt_mem_port_arbiter_pkg;

    localparam int WtArbMaxPorts    = 8;
    localparam int WtArbDefTidWidth = 2;

    // Port index width; a single port still carries one (always zero) index bit.
    function automatic int arb_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int arb_cnt_w(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

    typedef struct packed {
        logic [$clog2(WtArbMaxPorts)-1:0] port_idx;
        logic [WtArbDefTidWidth-1:0]      tid;
    } wt_arb_tid_t;

endpackage

// File: rtl/wt_mem_port_arbiter_if.sv
// Client-side and adapter-side handshake bundle of the memory port arbiter.
interface wt_mem_port_arbiter_if #(
    parameter int NumPorts  = 2,
    parameter int ReqWidth  = 64,
    parameter int RtrnWidth = 128,
    parameter int TidWidth  = 2
);
    localparam int IdxW = wt_mem_port_arbiter_pkg::arb_idx_w(NumPorts);

    logic [NumPorts-1:0]          port_req_i;
    logic [NumPorts-1:0]          port_ack_o;
    logic [NumPorts*ReqWidth-1:0] port_data_i;
    logic [NumPorts*TidWidth-1:0] port_tid_i;
    logic                         mem_req_o;
    logic                         mem_ack_i;
    logic [ReqWidth-1:0]          mem_data_o;
    logic [TidWidth+IdxW-1:0]     mem_tid_o;
    logic                         mem_rtrn_vld_i;
    logic [RtrnWidth-1:0]         mem_rtrn_i;
    logic [TidWidth+IdxW-1:0]     mem_rtrn_tid_i;
    logic [NumPorts-1:0]          port_rtrn_vld_o;
    logic [RtrnWidth-1:0]         port_rtrn_o;
    logic [TidWidth-1:0]          port_rtrn_tid_o;
    logic                         idle_o;
    logic                         err_o;

    modport master (
        input  port_req_i, port_data_i, port_tid_i,
        input  mem_ack_i, mem_rtrn_vld_i, mem_rtrn_i, mem_rtrn_tid_i,
        output port_ack_o, mem_req_o, mem_data_o, mem_tid_o,
        output port_rtrn_vld_o, port_rtrn_o, port_rtrn_tid_o, idle_o, err_o
    );

    modport slave (
        output port_req_i, port_data_i, port_tid_i,
        output mem_ack_i, mem_rtrn_vld_i, mem_rtrn_i, mem_rtrn_tid_i,
        input  port_ack_o, mem_req_o, mem_data_o, mem_tid_o,
        input  port_rtrn_vld_o, port_rtrn_o, port_rtrn_tid_o, idle_o, err_o
    );

endinterface

// File: rtl/wt_mem_port_credit.sv
// Per-port outstanding-transaction counter; saturates at both ends and
// cancels out a simultaneous issue and return.
module wt_mem_port_credit
    import wt_mem_port_arbiter_pkg::*;
#(
    parameter int MaxOutstanding = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o,
    output logic empty_next_o
);
    localparam int CntW = arb_cnt_w(MaxOutstanding);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign full_o       = (cnt_q == CntW'(MaxOutstanding));
    assign empty_o      = (cnt_q == '0);
    assign empty_next_o = (cnt_d == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wt_mem_port_arbiter.sv
// N-port round-robin arbiter merging write-through cache clients onto one
// memory adapter channel, with per-port credits and ID-based return routing.
module wt_mem_port_arbiter
    import wt_mem_port_arbiter_pkg::*;
#(
    parameter int NumPorts       = 2,
    parameter int ReqWidth       = 64,
    parameter int RtrnWidth      = 128,
    parameter int TidWidth       = 2,
    parameter int MaxOutstanding = 4
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    wt_mem_port_arbiter_if.master bus
);
    localparam int IdxW = arb_idx_w(NumPorts);

    logic [NumPorts-1:0]  full;
    logic [NumPorts-1:0]  empty;
    logic [NumPorts-1:0]  empty_next;
    logic [NumPorts-1:0]  eligible;
    logic [NumPorts-1:0]  port_ack;
    logic [NumPorts-1:0]  rtrn_hit;

    logic                 sel_found;
    logic [IdxW-1:0]      sel_idx;
    logic [IdxW-1:0]      grant_idx;
    logic                 mem_req;
    logic [ReqWidth-1:0]  mem_data;
    logic [TidWidth-1:0]  mem_tid_local;
    logic [IdxW-1:0]      rtrn_idx;

    logic                 lock_q, lock_d;
    logic [IdxW-1:0]      lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NumPorts-1:0]  rtrn_vld_q, rtrn_vld_d;
    logic [RtrnWidth-1:0] rtrn_q, rtrn_d;
    logic [TidWidth-1:0]  rtrn_tid_q, rtrn_tid_d;
    logic                 err_q, err_d;
    logic                 idle_q, idle_d;

    for (genvar k = 0; k < NumPorts; k++) begin : g_credit
        wt_mem_port_credit #(
            .MaxOutstanding (MaxOutstanding)
        ) i_credit (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .inc_i        (port_ack[k]),
            .dec_i        (rtrn_hit[k]),
            .full_o       (full[k]),
            .empty_o      (empty[k]),
            .empty_next_o (empty_next[k])
        );
    end

    assign eligible = bus.port_req_i & ~full;

    // First eligible port at or after the round-robin pointer, with wrap-around.
    always_comb begin
        int p;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 0; off < NumPorts; off++) begin
            p = int'(rr_ptr_q) + off;
            if (p >= NumPorts) begin
                p = p - NumPorts;
            end
            if (!sel_found && eligible[p]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(p);
            end
        end
    end

    // A pending un-acked grant owns the channel until the adapter accepts it.
    assign grant_idx = lock_q ? lock_idx_q : sel_idx;
    assign mem_req   = lock_q | sel_found;

    always_comb begin
        mem_data      = '0;
        mem_tid_local = '0;
        port_ack      = '0;
        for (int k = 0; k < NumPorts; k++) begin
            if (grant_idx == IdxW'(k)) begin
                mem_data      = bus.port_data_i[k*ReqWidth +: ReqWidth];
                mem_tid_local = bus.port_tid_i[k*TidWidth +: TidWidth];
                port_ack[k]   = mem_req & bus.mem_ack_i;
            end
        end
    end

    assign rtrn_idx = bus.mem_rtrn_tid_i[TidWidth +: IdxW];

    // Returns outside the port range or to a port with nothing in flight hit no port.
    always_comb begin
        rtrn_hit = '0;
        for (int k = 0; k < NumPorts; k++) begin
            rtrn_hit[k] = bus.mem_rtrn_vld_i & (rtrn_idx == IdxW'(k)) & ~empty[k];
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (mem_req && bus.mem_ack_i) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant_idx == IdxW'(NumPorts - 1)) ? '0 : grant_idx + 1'b1;
        end else if (mem_req) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end

        rtrn_vld_d = rtrn_hit;
        rtrn_d     = rtrn_q;
        rtrn_tid_d = rtrn_tid_q;
        if (|rtrn_hit) begin
            rtrn_d     = bus.mem_rtrn_i;
            rtrn_tid_d = bus.mem_rtrn_tid_i[TidWidth-1:0];
        end

        err_d  = err_q | (bus.mem_rtrn_vld_i & ~(|rtrn_hit));
        idle_d = &empty_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            rtrn_vld_q <= '0;
            rtrn_q     <= '0;
            rtrn_tid_q <= '0;
            err_q      <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            rtrn_vld_q <= rtrn_vld_d;
            rtrn_q     <= rtrn_d;
            rtrn_tid_q <= rtrn_tid_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
        end
    end

    assign bus.port_ack_o      = port_ack;
    assign bus.mem_req_o       = mem_req;
    assign bus.mem_data_o      = mem_data;
    assign bus.mem_tid_o       = {grant_idx, mem_tid_local};
    assign bus.port_rtrn_vld_o = rtrn_vld_q;
    assign bus.port_rtrn_o     = rtrn_q;
    assign bus.port_rtrn_tid_o = rtrn_tid_q;
    assign bus.idle_o          = idle_q;
    assign bus.err_o           = err_q;

endmodule

// File: tb/tb_wt_mem_port_arbiter.sv
// Self-checking bench for wt_mem_port_arbiter: directed scenarios plus a
// randomized phase, all compared against a behavioural credit/round-robin model.
module tb_wt_mem_port_arbiter;

    localparam int N   = 3;
    localparam int RW  = 64;
    localparam int RTW = 128;
    localparam int TW  = 2;
    localparam int MO  = 4;
    localparam int IW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wt_mem_port_arbiter_if #(
        .NumPorts (N), .ReqWidth (RW), .RtrnWidth (RTW), .TidWidth (TW)
    ) bus ();

    wt_mem_port_arbiter #(
        .NumPorts (N), .ReqWidth (RW), .RtrnWidth (RTW), .TidWidth (TW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus state
    logic [N-1:0]    req_a;
    logic [RW-1:0]   data_a [N];
    logic [TW-1:0]   tid_a  [N];
    logic            ack_a;
    logic            rtrn_vld_a;
    logic [IW+TW-1:0] rtrn_tid_a;
    logic [RTW-1:0]  rtrn_data_a;

    // Behavioural model: in-flight count per port, fairness pointer, grant hold
    int              cnt_m [N];
    int              rr_m;
    bit              lock_m;
    int              lock_idx_m;
    bit              err_m;
    logic [N-1:0]    rvld_m;
    logic [RTW-1:0]  rdata_m;
    logic [TW-1:0]   rtid_m;
    bit              exp_req;
    int              exp_g;
    logic [N-1:0]    exp_ack;

    task automatic cmp(input string name, input logic [RTW-1:0] act, input logic [RTW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_idle();
        for (int k = 0; k < N; k++) begin
            if (cnt_m[k] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < N; k++) cnt_m[k] = 0;
        rr_m       = 0;
        lock_m     = 1'b0;
        lock_idx_m = 0;
        err_m      = 1'b0;
        rvld_m     = '0;
        rdata_m    = '0;
        rtid_m     = '0;
    endtask

    task automatic driveBus();
        for (int k = 0; k < N; k++) begin
            bus.port_data_i[k*RW +: RW] = data_a[k];
            bus.port_tid_i[k*TW +: TW]  = tid_a[k];
        end
        bus.port_req_i     = req_a;
        bus.mem_ack_i      = ack_a;
        bus.mem_rtrn_vld_i = rtrn_vld_a;
        bus.mem_rtrn_tid_i = rtrn_tid_a;
        bus.mem_rtrn_i     = rtrn_data_a;
    endtask

    task automatic setReq(input int k, input int tid, input logic [RW-1:0] data);
        req_a[k]  = 1'b1;
        tid_a[k]  = TW'(tid);
        data_a[k] = data;
    endtask

    task automatic setRtrn(input int idx, input int tid);
        rtrn_vld_a  = 1'b1;
        rtrn_tid_a  = (IW+TW)'(idx * (1 << TW) + tid);
        rtrn_data_a = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Expected combinational outputs from the current model state and inputs,
    // followed by the comparison of every output against the model.
    task automatic checkOutput();
        bit found;
        int p;
        found   = 1'b0;
        exp_req = 1'b0;
        exp_g   = 0;
        if (lock_m) begin
            exp_req = 1'b1;
            exp_g   = lock_idx_m;
        end else begin
            for (int off = 0; off < N; off++) begin
                p = (rr_m + off) % N;
                if (!found && req_a[p] && cnt_m[p] < MO) begin
                    found   = 1'b1;
                    exp_req = 1'b1;
                    exp_g   = p;
                end
            end
        end
        exp_ack = (exp_req && ack_a) ? N'(1 << exp_g) : '0;

        cmp("mem_req", RTW'(bus.mem_req_o), RTW'(exp_req));
        cmp("port_ack", RTW'(bus.port_ack_o), RTW'(exp_ack));
        if (exp_req) begin
            cmp("mem_data", RTW'(bus.mem_data_o), RTW'(data_a[exp_g]));
            cmp("mem_tid", RTW'(bus.mem_tid_o), RTW'(exp_g * (1 << TW) + int'(tid_a[exp_g])));
        end
        cmp("rtrn_vld", RTW'(bus.port_rtrn_vld_o), RTW'(rvld_m));
        cmp("rtrn_data", bus.port_rtrn_o, rdata_m);
        cmp("rtrn_tid", RTW'(bus.port_rtrn_tid_o), RTW'(rtid_m));
        cmp("idle", RTW'(bus.idle_o), RTW'(model_idle()));
        cmp("err", RTW'(bus.err_o), RTW'(err_m));
    endtask

    // Model state update for the coming clock edge.
    task automatic advanceModel();
        int idx;
        rvld_m = '0;
        if (rtrn_vld_a) begin
            idx = int'(rtrn_tid_a) >> TW;
            if (idx < N && cnt_m[idx] > 0) begin
                cnt_m[idx]--;
                rvld_m  = N'(1 << idx);
                rdata_m = rtrn_data_a;
                rtid_m  = rtrn_tid_a[TW-1:0];
            end else begin
                err_m = 1'b1;
            end
        end
        if (exp_req && ack_a) begin
            cnt_m[exp_g]++;
            rr_m   = (exp_g + 1) % N;
            lock_m = 1'b0;
        end else if (exp_req) begin
            lock_m     = 1'b1;
            lock_idx_m = exp_g;
        end
    endtask

    task automatic tickBegin();
        driveBus();
        #1;
        checkOutput();
    endtask

    task automatic tickEnd();
        advanceModel();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (exp_ack[k]) req_a[k] = 1'b0;
        end
        rtrn_vld_a = 1'b0;
    endtask

    task automatic tick();
        tickBegin();
        tickEnd();
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        req_a      = '0;
        ack_a      = 1'b0;
        rtrn_vld_a = 1'b0;
        modelReset();
        driveBus();
        #1;
        checkOutput();
        @(negedge clk);
        #1;
        checkOutput();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        int k;
        for (int i = 0; i < N; i++) begin
            if (!req_a[i] && $urandom_range(0, 99) < 60) begin
                setReq(i, $urandom_range(0, 3), {$urandom, $urandom});
            end
        end
        ack_a      = ($urandom_range(0, 99) < 65);
        rtrn_vld_a = 1'b0;
        if ($urandom_range(0, 99) < 45) begin
            k = $urandom_range(0, N - 1);
            if (cnt_m[k] > 0) setRtrn(k, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            data_a[k] = '0;
            tid_a[k]  = '0;
        end
        rtrn_tid_a  = '0;
        rtrn_data_a = '0;
        @(negedge clk);
        doReset();
        cmp("reset_idle", RTW'(bus.idle_o), RTW'(1'b1));
        cmp("reset_mem_req", RTW'(bus.mem_req_o), RTW'(1'b0));

        // Single client on port 1
        setReq(1, 2, 64'hA5);
        ack_a = 1'b0;
        tickBegin();
        cmp("single_tid", RTW'(bus.mem_tid_o), RTW'(6));
        cmp("single_data", RTW'(bus.mem_data_o), RTW'(64'hA5));
        tickEnd();
        ack_a = 1'b1;
        tickBegin();
        cmp("single_ack", RTW'(bus.port_ack_o), RTW'(3'b010));
        tickEnd();
        ack_a = 1'b0;
        tickBegin();
        cmp("single_idle", RTW'(bus.idle_o), RTW'(1'b0));
        tickEnd();
        setRtrn(1, 2);
        tick();

        // Round-robin with all ports busy until credits run out
        ack_a = 1'b1;
        for (int c = 0; c < 15; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_a[k]) setReq(k, c % 4, {$urandom, $urandom});
            end
            tick();
        end
        tickBegin();
        cmp("rr_all_full", RTW'(bus.mem_req_o), RTW'(1'b0));
        tickEnd();

        // Credit stall on port 0
        doReset();
        ack_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            setReq(0, c, {$urandom, $urandom});
            tick();
        end
        setReq(0, 3, 64'h1234);
        setReq(1, 1, 64'h5678);
        tickBegin();
        cmp("stall_grant", RTW'(bus.port_ack_o), RTW'(3'b010));
        tickEnd();
        setRtrn(0, 1);
        tickBegin();
        cmp("stall_noreq", RTW'(bus.mem_req_o), RTW'(1'b0));
        tickEnd();
        tickBegin();
        cmp("stall_rvld", RTW'(bus.port_rtrn_vld_o), RTW'(3'b001));
        cmp("stall_rtid", RTW'(bus.port_rtrn_tid_o), RTW'(1));
        cmp("stall_regrant", RTW'(bus.port_ack_o), RTW'(3'b001));
        tickEnd();

        // Grant lock on port 2 while port 0 waits
        doReset();
        ack_a = 1'b0;
        setReq(2, 3, 64'hCAFE);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) setReq(0, 1, 64'hBEEF);
            tickBegin();
            cmp("lock_port", RTW'(bus.mem_tid_o >> TW), RTW'(2));
            tickEnd();
        end
        ack_a = 1'b1;
        tickBegin();
        cmp("lock_ack2", RTW'(bus.port_ack_o), RTW'(3'b100));
        tickEnd();
        tickBegin();
        cmp("lock_ack0", RTW'(bus.port_ack_o), RTW'(3'b001));
        tickEnd();

        // Same-cycle ack and return on port 1, then an out-of-range return
        ack_a = 1'b0;
        setRtrn(0, 1);
        tick();
        setRtrn(2, 3);
        tick();
        ack_a = 1'b1;
        setReq(1, 0, {$urandom, $urandom});
        tick();
        setReq(1, 2, {$urandom, $urandom});
        setRtrn(1, 0);
        tick();
        ack_a = 1'b0;
        setRtrn(1, 2);
        tick();
        tickBegin();
        cmp("simul_rvld", RTW'(bus.port_rtrn_vld_o), RTW'(3'b010));
        cmp("simul_idle", RTW'(bus.idle_o), RTW'(1'b1));
        tickEnd();
        setRtrn(3, 0);
        tick();
        tickBegin();
        cmp("err_set", RTW'(bus.err_o), RTW'(1'b1));
        cmp("err_novld", RTW'(bus.port_rtrn_vld_o), RTW'(3'b000));
        tickEnd();
        for (int c = 0; c < 3; c++) tick();
        tickBegin();
        cmp("err_sticky", RTW'(bus.err_o), RTW'(1'b1));
        tickEnd();

        // Reset with transactions in flight
        doReset();
        ack_a = 1'b1;
        setReq(0, 0, {$urandom, $urandom});
        tick();
        setReq(0, 1, {$urandom, $urandom});
        tick();
        setReq(1, 2, {$urandom, $urandom});
        tick();
        ack_a = 1'b0;
        doReset();
        cmp("midrst_idle", RTW'(bus.idle_o), RTW'(1'b1));
        cmp("midrst_err", RTW'(bus.err_o), RTW'(1'b0));
        setRtrn(0, 0);
        tick();
        tickBegin();
        cmp("stale_rtrn_err", RTW'(bus.err_o), RTW'(1'b1));
        tickEnd();

        // Randomized traffic
        doReset();
        for (int c = 0; c < 1500; c++) begin
            applyStimulus();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wt_mem_port_arbiter.md
Name: wt_mem_port_arbiter

Overview:
N-port memory-side arbiter that merges several write-through cache clients onto one memory adapter request channel. Clients are I$, D$ and future clients such as a second D$ port or a prefetcher. It generalises the fixed two-client icache/dcache plumbing in three ways:
- parametrised client count;
- per-port outstanding-transaction credit limits;
- transaction-ID tagging, with return routing back to the issuing port.
It sits between the L1 caches and wt_axi_adapter/wt_l15_adapter.

Parameters:
NumPorts, 2, number of client ports (2..8).
ReqWidth, 64, request payload width (addr/data/size/type bundle) per port.
RtrnWidth, 128, return payload width.
TidWidth, 2, per-port local transaction ID width.
MaxOutstanding, 4, max in-flight requests per port (1..15).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
port_req_i  in  NumPorts  per-port request valid; held until acked
port_ack_o  out  NumPorts  one-cycle accept pulse per port
port_data_i  in  NumPorts*ReqWidth  per-port payload, port k at bits [k*ReqWidth +: ReqWidth]
port_tid_i  in  NumPorts*TidWidth  per-port local ID
mem_req_o  out  1  request valid to adapter
mem_ack_i  in  1  adapter accepts current request
mem_data_o  out  ReqWidth  granted payload
mem_tid_o  out  TidWidth+IdxW  {port index, local tid}; IdxW = max(1, clog2(NumPorts))
mem_rtrn_vld_i  in  1  return valid from adapter
mem_rtrn_i  in  RtrnWidth  return payload
mem_rtrn_tid_i  in  TidWidth+IdxW  return ID
port_rtrn_vld_o  out  NumPorts  one-hot return valid
port_rtrn_o  out  RtrnWidth  return payload, broadcast to all ports
port_rtrn_tid_o  out  TidWidth  local tid of the return
idle_o  out  1  all credit counters zero
err_o  out  1  sticky protocol error

Behaviour:
- Reset values (async, rst_ni low): port_ack_o=0, mem_req_o=0, port_rtrn_vld_o=0, port_rtrn_o=0, port_rtrn_tid_o=0, err_o=0, idle_o=1. All credit counters are 0, the RR pointer is 0, and the lock is cleared.
- Eligibility: port k is eligible when port_req_i[k]=1 and cnt[k] < MaxOutstanding.
- Arbitration: round-robin among eligible ports, searching from rr_ptr upward with wrap-around.
- Grant lock: once mem_req_o=1 for port k, the grant is held, and mem_data_o/mem_tid_o stay stable, until mem_ack_i. Other ports cannot pre-empt.
- Request path is combinational: mem_req_o = locked-or-selected port valid.
  - port_ack_o[k] = mem_ack_i & grant==k, in the same cycle.
  - On ack: rr_ptr <= k+1 (wraps to 0 after NumPorts-1), lock is cleared, cnt[k]++.
- A port at cnt==MaxOutstanding is skipped and never granted; it becomes eligible the cycle after its count drops.
- Return path is registered, 1-cycle latency:
  - mem_rtrn_vld_i with upper IdxW bits = j gives, next cycle, port_rtrn_vld_o[j]=1, port_rtrn_o=mem_rtrn_i, port_rtrn_tid_o = low TidWidth bits.
  - At the return cycle, cnt[j]--.
- Same-cycle ack and return on the same port: cnt is unchanged.
- Return with index >= NumPorts, or to a port with cnt==0: err_o is set (sticky until reset), no port_rtrn_vld_o, no counter change.
- idle_o = all cnt==0, registered from the counters.
- Counter width is clog2(MaxOutstanding+1); it never wraps.
- Reset mid-transaction: all state is cleared immediately. Returns for pre-reset IDs arriving later raise err_o.
- mem_ack_i while mem_req_o=0 is ignored.
- NumPorts=1: arbiter degenerates to pass-through with credit limiting; mem_tid_o MSB is 0.

Decomposition:
- wt_cache_pkg gets:
  - constant WtArbMaxPorts=8;
  - function for IdxW;
  - typedef wt_arb_tid_t for the tagged ID.
- Sub-module wt_mem_port_credit: one per port, holds an up/down saturating counter with inc/dec/full/empty outputs.
- Round-robin selection is inline, or uses the existing rr_arb_tree with LockIn=1.

Test Plan:
- Request path, single client (NumPorts=3, ports 0 and 2 idle): port 1 req, tid=2, data=0xA5 → mem_req_o=1, mem_tid_o=6 ({1,2}), mem_data_o=0xA5. mem_ack_i then gives port_ack_o=3'b010 in the same cycle. cnt[1]=1, idle_o=0.
- Round-robin fairness: ports 0,1,2 requesting continuously, mem_ack_i=1 every cycle → grant order 0,1,2,0,…; each port acked once per 3 cycles until its credits run out at 4.
- Credit stall: port 0 issues 4 requests with no returns → 5th request is not granted and port 1 is granted instead. A return with tid {0,1} gives port_rtrn_vld_o=3'b001 and port_rtrn_tid_o=1 one cycle later. Port 0 is granted again on the following cycle.
- Lock: port 2 is granted, mem_ack_i is held low for 5 cycles, port 0 asserts meanwhile → mem_tid_o stays at port 2 for all 5 cycles, and port 0 is served only after the ack.
- Simultaneous events and error: ack port 1 and return to port 1 in the same cycle → cnt[1] unchanged. Return with index 3 when NumPorts=3 → err_o=1 and stays 1, port_rtrn_vld_o=0.
- Reset mid-flight: rst_ni low with cnt={2,1,0} → next cycle all outputs are at reset values, idle_o=1.
